alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1: command push handshake.
REQ-005 SHALL have port cmd_oper  input  3  ALU operation code, passed through unchanged.
REQ-006 SHALL have ports cmd_a input 8, cmd_b input 8: operands.
REQ-007 SHALL have port cmd_src_acc  input  1  1: ALU a = accumulator, 0: a = cmd_a.
REQ-008 SHALL have port cmd_use_cy  input  1  1: ALU c_in = carry flag, 0: c_in = 0.
REQ-009 SHALL have port cmd_clr  input  1  clear accumulator and carry flag before this op.
REQ-010 SHALL have ports oper output 3, a output 8, b output 8, c_in output 1: registered drive to the downstream ALU.
REQ-011 SHALL have ports alu_c_out input 1, alu_sum input 8: combinational ALU result.
REQ-012 SHALL have ports res_valid output 1, res_ready input 1, res_sum output 8, res_c_out output 1: result handshake.
REQ-013 SHALL have ports acc output 8, cy output 1, ops_done output 8: architectural state.

Function
REQ-014 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-015 SHALL drive cmd_ready = 1 exactly when FIFO count < FIFO_DEPTH; a push while full is not possible.
REQ-016 SHALL support simultaneous push and pop in one cycle, including at full (pop frees slot only on the next cycle; cmd_ready is not combinationally raised by a pop) and at empty (push and pop cannot coincide; entry becomes poppable the cycle after push).
REQ-017 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH without loss or duplication.
REQ-018 SHALL implement FSM with states IDLE and EXEC.
REQ-019 IDLE -> EXEC SHALL occur when the FIFO is non-empty and (res_valid == 0 or res_ready == 1); on that edge: pop one entry, load oper = cmd_oper, b = cmd_b, a = (src_acc ? acc' : cmd_a), c_in = (use_cy ? cy' : 0), where acc'/cy' are 0 if cmd_clr else current acc/cy.
REQ-020 cmd_clr SHALL also load acc = 0 and cy = 0 on the IDLE -> EXEC edge.
REQ-021 EXEC -> IDLE SHALL occur unconditionally on the next edge; on that edge: acc = alu_sum, cy = alu_c_out, res_sum = alu_sum, res_c_out = alu_c_out, res_valid = 1, ops_done = ops_done + 1.
REQ-022 ops_done SHALL wrap 0xFF -> 0x00.
REQ-023 res_valid SHALL clear on an edge with res_valid & res_ready unless a new capture occurs on that same edge; res_sum/res_c_out SHALL hold while res_valid & !res_ready.
REQ-024 Latency: command pushed at edge N into empty FIFO, idle FSM, free result slot -> issued at edge N+1, res_valid = 1 after edge N+2.
REQ-025 Throughput SHALL be one command per 2 cycles when res_ready is held 1.
REQ-026 oper/a/b/c_in SHALL hold their last values while in IDLE.

Reset
REQ-027 On rst = 1 at a rising edge: FIFO emptied, FSM = IDLE, acc = 0, cy = 0, ops_done = 0, res_valid = 0, res_sum = 0, res_c_out = 0, oper = 0, a = 0, b = 0, c_in = 0; cmd_ready = 1 after the edge.
REQ-028 rst SHALL dominate all other events, including a push, pop or capture on the same edge; an in-flight EXEC op is discarded.

Verification (ALU stubbed as {alu_c_out, alu_sum} = a + b + c_in, oper ignored)
REQ-029 Single op: cmd_a = 0xD2, cmd_b = 0xB6, src_acc = 0, use_cy = 0 -> after 2 edges res_sum = 0x88, res_c_out = 1, acc = 0x88, cy = 1, ops_done = 1.
REQ-030 Carry chain: then src_acc = 1, use_cy = 1, cmd_b = 0x01 -> a = 0x88, c_in = 1, res_sum = 0x8A, cy = 0.
REQ-031 Clear: cmd_clr = 1, src_acc = 1, use_cy = 1, cmd_b = 0x05 -> a = 0x00, c_in = 0, res_sum = 0x05.
REQ-032 Backpressure/full: res_ready = 0, push 6 commands -> 1 issued, 1 result held, FIFO holds 4, cmd_ready = 0; raise res_ready -> all 5 remaining results delivered in order, none lost.
REQ-033 Wrap: 256 ops -> ops_done = 0x00; FIFO pointers wrap with correct ordering.
REQ-034 Reset mid-op: assert rst while FSM in EXEC with 2 queued -> next cycle res_valid = 0, acc = 0, cmd_ready = 1, no result emitted.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Queues ALU commands in a small FIFO and issues them one at a time to an
// external combinational ALU. The sequencer keeps an 8-bit accumulator and a
// carry flag so that commands can chain on previous results (multi-byte
// arithmetic). Each result is presented on a valid/ready result port.
//
// Parameters
//   FIFO_DEPTH   command FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command push handshake
//   cmd_oper [2:0]            ALU op code, forwarded unchanged
//   cmd_a, cmd_b [7:0]        operands
//   cmd_src_acc               1: ALU a = accumulator, 0: a = cmd_a
//   cmd_use_cy                1: ALU c_in = carry flag, 0: c_in = 0
//   cmd_clr                   clear accumulator and carry before this op
//   oper, a, b, c_in          registered drive to the downstream ALU
//   alu_sum, alu_c_out        combinational ALU result
//   res_valid / res_ready     result handshake
//   res_sum, res_c_out        captured result
//   acc, cy, ops_done         architectural state
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_oper,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_src_acc,
    input  logic       cmd_use_cy,
    input  logic       cmd_clr,

    output logic [2:0] oper,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       c_in,
    input  logic       alu_c_out,
    input  logic [7:0] alu_sum,

    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_sum,
    output logic       res_c_out,

    output logic [7:0] acc,
    output logic       cy,
    output logic [7:0] ops_done
);

    // -----------------------------------------------------------------------
    // Local constants and types
    // -----------------------------------------------------------------------
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = '0;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0] oper;
        logic [7:0] a;
        logic [7:0] b;
        logic       src_acc;
        logic       use_cy;
        logic       clr;
    } cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    cmd_t            r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    state_t          r_state;
    state_t          w_state_next;

    logic [2:0]      r_oper;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic            r_c_in;
    logic [7:0]      r_acc;
    logic            r_cy;
    logic [7:0]      r_ops_done;
    logic            r_res_valid;
    logic [7:0]      r_res_sum;
    logic            r_res_c_out;

    cmd_t            w_cmd_in;
    cmd_t            w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_capture;
    logic            w_can_issue;
    logic            w_not_empty;
    logic [7:0]      w_acc_pre;
    logic            w_cy_pre;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    assign w_cmd_in = {cmd_oper, cmd_a, cmd_b, cmd_src_acc, cmd_use_cy, cmd_clr};

    // Ready depends only on the registered count: a pop in the same cycle
    // frees its slot for the following cycle, never combinationally.
    assign cmd_ready   = (r_count < CNT_FULL);
    assign w_not_empty = (r_count != CNT_ZERO);
    assign w_push      = cmd_valid & cmd_ready;

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    // The head entry feeds the issue logic directly so a command can be
    // issued on the same edge it is popped.
    assign w_head = r_fifo_mem[r_rd_ptr];

    // Pointers are exactly AW bits wide, so power-of-two wrap is implicit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Issue FSM
    // -----------------------------------------------------------------------
    // An issue needs a queued command and a result slot that is either empty
    // or being drained on this same edge, so an unread result is never
    // overwritten by the capture that follows.
    assign w_can_issue = w_not_empty & (~r_res_valid | res_ready);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_can_issue) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The ALU is combinational: one cycle of EXEC is enough.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output (control strobe) logic
    always_comb begin
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: w_pop     = w_can_issue;
            ST_EXEC: w_capture = 1'b1;
            default: begin
                w_pop     = 1'b0;
                w_capture = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    // Accumulator and carry as seen by the command being issued: a clear
    // command sees zeros even though the registers only clear on this edge.
    assign w_acc_pre = w_head.clr ? 8'h00 : r_acc;
    assign w_cy_pre  = w_head.clr ? 1'b0  : r_cy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oper      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c_in      <= 1'b0;
            r_acc       <= '0;
            r_cy        <= 1'b0;
            r_ops_done  <= '0;
            r_res_sum   <= '0;
            r_res_c_out <= 1'b0;
        end else if (w_pop) begin
            // ALU drive registers change only here, so they hold in IDLE.
            r_oper <= w_head.oper;
            r_a    <= w_head.src_acc ? w_acc_pre : w_head.a;
            r_b    <= w_head.b;
            r_c_in <= w_head.use_cy ? w_cy_pre : 1'b0;
            if (w_head.clr) begin
                r_acc <= 8'h00;
                r_cy  <= 1'b0;
            end
        end else if (w_capture) begin
            r_acc       <= alu_sum;
            r_cy        <= alu_c_out;
            r_res_sum   <= alu_sum;
            r_res_c_out <= alu_c_out;
            r_ops_done  <= r_ops_done + 8'd1;
        end
    end

    // A capture always wins over a drain on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
        end else if (r_res_valid & res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign oper      = r_oper;
    assign a         = r_a;
    assign b         = r_b;
    assign c_in      = r_c_in;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_c_out = r_res_c_out;
    assign acc       = r_acc;
    assign cy        = r_cy;
    assign ops_done  = r_ops_done;

endmodule
